pci_target_mem: RTL
===================

# pci_target_mem

- Memory-space target backend for the PCI core's user side.
- Decodes a BAR hit into an on-chip synchronous word RAM.
- Accepts write bursts from `adio_out` and sources read bursts onto `adio_in`.
- Drives the target handshake outputs `s_ready`, `s_term` and `s_abort`.
- Sits directly downstream of the core's target port, alongside `user_interface`, and replaces its tied-off target outputs.

## Interface
- `DEPTH_LOG2`, 8: RAM depth is 2^DEPTH_LOG2 32-bit words (default 1 KB window).
- `MAX_BURST`, 16: maximum data phases per transaction before disconnect; 1..2^DEPTH_LOG2.
- `clk` in 1: PCI clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `base_hit` in 1: one-cycle pulse marking the start of a memory-BAR transaction; `addr` is valid in this cycle.
- `s_wrdn` in 1: 1 = write (master to target), 0 = read; sampled with `base_hit`.
- `s_data` in 1: high for the whole data-phase window of the transaction.
- `s_data_vld` in 1: a write data phase completes this cycle (`adio_out` and `s_cbe` valid).
- `s_src_en` in 1: the core consumed the current read word; target must present the next one.
- `addr` in 32: transaction address; `[DEPTH_LOG2+1:2]` is the word index, `[1:0]` is the burst order.
- `adio_out` in 32: write data from the core.
- `s_cbe` in 4: active-low byte enables for the current write phase.
- `adio_in` out 32: read data to the core.
- `s_ready` out 1: target ready for a data phase.
- `s_term` out 1: target disconnect request.
- `s_abort` out 1: target-abort request.

## Operation
- FSM states: IDLE, WRITE, RFILL, READ, ABORT, DRAIN.
- IDLE, `base_hit` with `addr[1:0]!=0` (non-linear burst order): go to ABORT.
  - ABORT asserts `s_abort` for 1 cycle, then goes to DRAIN.
- IDLE, `base_hit` with `addr[1:0]==0`:
  - Load `ptr` from the word index; clear `cnt`.
  - Go to WRITE if `s_wrdn`=1, else RFILL.
- WRITE:
  - `s_ready`=1.
  - Each cycle with `s_data_vld`: write `adio_out` to `ram[ptr]`, then `ptr++` and `cnt++`.
- RFILL: issues the RAM read of `ram[ptr]`, then goes to READ.
- READ:
  - `s_ready`=1 and `adio_in`=`ram[ptr]`.
  - RAM read address is `ptr+1` when `s_src_en`=1, else `ptr`, so consecutive words stream with no bubble.
  - On `s_src_en`: `ptr++`, `cnt++`.
- Disconnect: `s_term`=1 from the cycle the current phase is the last allowed one until the FSM leaves the state. The last allowed phase is either:
  - `ptr==2^DEPTH_LOG2-1`, or
  - `cnt==MAX_BURST-1`.
- End of transaction: `s_data` low in WRITE, READ or DRAIN returns to IDLE. `s_ready`, `s_term` and `s_abort` drop in that same cycle's registered update.
- `ptr` saturates at the last word and never wraps. Write phases that arrive after a saturated last-word write are discarded.
- `base_hit` is ignored outside IDLE.
- The core never asserts `s_data_vld` and `s_src_en` together. If both are seen, the one matching the latched direction wins.

## Timing
- All outputs are registered.
- Reset values: `adio_in`=0, `s_ready`=0, `s_term`=0, `s_abort`=0, FSM=IDLE, `ptr`=0, `cnt`=0.
- RAM contents are not reset and survive `rst`.
- Write: `base_hit` at T0 gives `s_ready`=1 at T1. A write phase at Tn is readable by a read starting at Tn+1 or later.
- Read: `base_hit` at T0, RAM read at T1, `adio_in` valid with `s_ready`=1 at T2 (one wait state).
  - After that, one word per cycle while `s_src_en`=1.
  - `adio_in` holds its value while `s_src_en`=0.
- Abort: `base_hit` at T0 gives `s_abort`=1 at T1 only. `s_ready` stays 0.
- `rst` mid-transaction: outputs go to reset values immediately (asynchronous) and the FSM returns to IDLE. No partial write occurs after reset assertion.

## Configuration
- `PCI_TGT_BYTE_MASK_EN` defined:
  - Each write updates only the bytes whose `s_cbe[i]`=0.
  - `s_cbe`=4'hF is a valid no-op phase: `ptr` and `cnt` still advance.
- Undefined: `s_cbe` is ignored and every write phase writes all 4 bytes.

## Test plan
- Reset, then write 4 words 0x11111111..0x44444444 at word 0, then read a 4-phase burst from word 0:
  - `adio_in` returns 0x11111111..0x44444444 starting 2 cycles after `base_hit`, one per `s_src_en`.
  - `s_term`=0 throughout.
- Write burst of 20 phases at word 0 with `MAX_BURST`=16: `s_term` rises during phase 16 (`cnt`=15); phases 17-20 are not issued by the bench model; read-back of word 15 is correct.
- Read starting at word 2^DEPTH_LOG2-2: `s_term`=1 with the second word; `ptr` saturates at 255 and no wrap to word 0 is observed.
- `base_hit` with `addr`=0x00000006: `s_abort`=1 for exactly 1 cycle; `s_ready` stays 0; a subsequent readback shows RAM unchanged.
- With `PCI_TGT_BYTE_MASK_EN`:
  - Word 3 = 0xAABBCCDD.
  - Write 0x11223344 with `s_cbe`=4'b1010.
  - Read returns 0xAA22CC44.
  - Without the macro, the same write returns 0x11223344.
- Assert `rst` mid-way through an 8-phase write burst:
  - Outputs are 0 in the same cycle.
  - A new transaction after release works normally.
  - Words written before reset read back intact.

Source files
------------

// File: rtl/pci_target_mem.sv
// Memory-space PCI target backend: maps a BAR window onto a synchronous word RAM with burst
// write/read, disconnect and target-abort. Define PCI_TGT_BYTE_MASK_EN to honour s_cbe byte enables.
`timescale 1ns/1ps
module pci_target_mem #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        base_hit,
  input  logic        s_wrdn,
  input  logic        s_data,
  input  logic        s_data_vld,
  input  logic        s_src_en,
  input  logic [31:0] addr,
  input  logic [31:0] adio_out,
  input  logic [3:0]  s_cbe,
  output logic [31:0] adio_in,
  output logic        s_ready,
  output logic        s_term,
  output logic        s_abort
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = '1;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RFILL, READ, ABORT, DRAIN} state_t;

  state_t                  state, state_n;
  logic [DEPTH_LOG2-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    full, full_n;
  logic                    s_ready_n, s_term_n, s_abort_n;
  logic                    we, rd_en;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic [31:0]             ram [0:DEPTH-1];
  logic                    unused_ok;

`ifdef PCI_TGT_BYTE_MASK_EN
  assign unused_ok = ^addr[31:DEPTH_LOG2+2];
`else
  assign unused_ok = ^{s_cbe, addr[31:DEPTH_LOG2+2]};
`endif

  // Control state and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      s_ready <= 1'b0;
      s_term  <= 1'b0;
      s_abort <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      full    <= full_n;
      s_ready <= s_ready_n;
      s_term  <= s_term_n;
      s_abort <= s_abort_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    full_n  = full;
    we      = 1'b0;
    rd_en   = 1'b0;
    rd_addr = ptr;
    case (state)
      IDLE: begin
        if (base_hit) begin
          if (addr[1:0] != 2'b00) begin
            state_n = ABORT;
          end else begin
            ptr_n   = addr[DEPTH_LOG2+1:2];
            cnt_n   = '0;
            full_n  = 1'b0;
            state_n = s_wrdn ? WRITE : RFILL;
          end
        end
      end
      WRITE: begin
        // A write landing on the last word sets full; later phases are dropped.
        if (s_data_vld && !full) begin
          we = 1'b1;
          if (ptr == LAST_WORD) full_n = 1'b1;
          else                  ptr_n  = ptr + 1'b1;
          if (cnt != LAST_CNT) cnt_n = cnt + 1'b1;
        end
        if (!s_data) state_n = IDLE;
      end
      RFILL: begin
        rd_en   = 1'b1;
        state_n = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (s_src_en) begin
          rd_addr = (ptr == LAST_WORD) ? ptr : ptr + 1'b1;
          ptr_n   = rd_addr;
          if (cnt != LAST_CNT) cnt_n = cnt + 1'b1;
        end
        if (!s_data) state_n = IDLE;
      end
      ABORT: state_n = DRAIN;
      DRAIN: if (!s_data) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    s_ready_n = (state_n == WRITE) || (state_n == READ);
    s_term_n  = s_ready_n && ((ptr_n == LAST_WORD) || (cnt_n == LAST_CNT));
    s_abort_n = (state_n == ABORT);
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef PCI_TGT_BYTE_MASK_EN
      for (int i = 0; i < 4; i++) begin
        if (!s_cbe[i]) ram[ptr][8*i +: 8] <= adio_out[8*i +: 8];
      end
`else
      ram[ptr] <= adio_out;
`endif
    end
  end

  // RAM read register doubles as the adio_in output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        adio_in <= '0;
    else if (rd_en) adio_in <= ram[rd_addr];
  end

endmodule
